brush_painter: RTL and testbench

BRUSH_PAINTER -- requirements
Module: brush_painter

---
 rtl/paint_pkg.sv | 36 +++
 rtl/cmd_fifo.sv | 48 ++++
 rtl/brush_painter.sv | 172 +++++++++++++++++
 tb/tb_brush_painter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/paint_pkg.sv
`default_nettype none
// ============================================================================
// Module  : paint_pkg
// Brief   : Shared types and screen defaults for the brush painter.
// Revision: 1.0 - initial release
// ============================================================================
package paint_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

  typedef logic [2:0] color_t;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    color_t     color;
    logic [1:0] size;
  } brush_cmd_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_PAINT = 1'b1
  } painter_state_t;

  function automatic logic signed [3:0] size_s(input logic [1:0] s);
    return $signed({2'b00, s});
  endfunction

  // Centre plus signed offset in 9-bit two's complement; bit 8 set means negative.
  function automatic logic [8:0] pix_coord(input logic [7:0] c, input logic signed [3:0] d);
    return {1'b0, c} + {{5{d[3]}}, d};
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module  : cmd_fifo
// Brief   : Show-ahead command FIFO, power-of-two depth, async active-low reset.
// Revision: 1.0 - initial release
// ============================================================================
module cmd_fifo
  import paint_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  brush_cmd_t din,
  output brush_cmd_t dout,
  output logic       full,
  output logic       empty
);

  localparam int            c_AW  = $clog2(DEPTH);
  localparam logic [c_AW:0] c_ONE = 1;

  brush_cmd_t    r_mem [DEPTH];
  logic [c_AW:0] r_wr;
  logic [c_AW:0] r_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (push) r_wr <= r_wr + c_ONE;
      if (pop)  r_rd <= r_rd + c_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr[c_AW-1:0]] <= din;
  end

  assign dout  = r_mem[r_rd[c_AW-1:0]];
  assign empty = (r_wr == r_rd);
  assign full  = (r_wr[c_AW] != r_rd[c_AW]) && (r_wr[c_AW-1:0] == r_rd[c_AW-1:0]);

endmodule
`default_nettype wire

// File: rtl/brush_painter.sv
`default_nettype none
// ============================================================================
// Module  : brush_painter
// Brief   : Queues brush points and rasterises clipped square brushes into
//           framebuffer writes. Define BRUSH_PAINTER_DROPCNT_EN for dropCount.
// Revision: 1.0 - initial release
// ============================================================================
module brush_painter
  import paint_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SCREEN_W   = SCREEN_W_DEF,
  parameter int SCREEN_H   = SCREEN_H_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       brushUpdate,
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic [2:0] newColorUpdate,
  input  logic       updateConfig,
  input  logic       wrReady,
  output logic       wrEn,
  output logic [7:0] wrX,
  output logic [7:0] wrY,
  output logic [2:0] wrColor,
  output logic       busy,
  output logic       overflow,
  output logic [7:0] dropCount
);

  localparam logic [8:0] c_SW = 9'(SCREEN_W);
  localparam logic [8:0] c_SH = 9'(SCREEN_H);

  color_t         r_color;
  logic [1:0]     r_size;
  painter_state_t r_state;
  brush_cmd_t     r_cmd;
  logic signed [3:0] r_dx;
  logic signed [3:0] r_dy;

  brush_cmd_t w_din;
  brush_cmd_t w_dout;
  brush_cmd_t w_src;
  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic       w_drop;
  logic       w_adv;
  logic       w_last;
  logic       w_in;
  logic signed [3:0] w_ndx;
  logic signed [3:0] w_ndy;
  logic [8:0] w_px;
  logic [8:0] w_py;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_color <= '0;
      r_size  <= '0;
    end else if (updateConfig) begin
      r_color <= newColorUpdate;
      r_size  <= x[1:0];
    end
  end

  // Sampled before the config update lands, so a same-cycle pair uses the old config.
  assign w_din  = '{x: x, y: y, color: r_color, size: r_size};
  assign w_pop  = (r_state == ST_IDLE) && !w_empty;
  assign w_push = brushUpdate && (!w_full || w_pop);
  assign w_drop = brushUpdate && w_full && !w_pop;
  assign w_adv  = (r_state == ST_PAINT) && (!wrEn || wrReady);
  assign w_last = (r_dx == size_s(r_cmd.size)) && (r_dy == size_s(r_cmd.size));
  assign busy   = (r_state == ST_PAINT) || !w_empty;

  cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  // Next pixel to present: first pixel of the popped command, or raster step.
  always_comb begin
    w_src = r_cmd;
    w_ndx = r_dx;
    w_ndy = r_dy;
    if (r_state == ST_IDLE) begin
      w_src = w_dout;
      w_ndx = -size_s(w_dout.size);
      w_ndy = -size_s(w_dout.size);
    end else if (r_dx == size_s(r_cmd.size)) begin
      w_ndx = -size_s(r_cmd.size);
      w_ndy = r_dy + 4'sd1;
    end else begin
      w_ndx = r_dx + 4'sd1;
    end
  end

  assign w_px = pix_coord(w_src.x, w_ndx);
  assign w_py = pix_coord(w_src.y, w_ndy);
  assign w_in = !w_px[8] && !w_py[8] && (w_px < c_SW) && (w_py < c_SH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cmd    <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      wrEn     <= 1'b0;
      wrX      <= '0;
      wrY      <= '0;
      wrColor  <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= w_drop;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_state <= ST_PAINT;
            r_cmd   <= w_dout;
            r_dx    <= w_ndx;
            r_dy    <= w_ndy;
            wrEn    <= w_in;
            wrX     <= w_px[7:0];
            wrY     <= w_py[7:0];
            wrColor <= w_src.color;
          end
        end
        ST_PAINT: begin
          if (w_adv) begin
            if (w_last) begin
              r_state <= ST_IDLE;
              wrEn    <= 1'b0;
            end else begin
              r_dx    <= w_ndx;
              r_dy    <= w_ndy;
              wrEn    <= w_in;
              wrX     <= w_px[7:0];
              wrY     <= w_py[7:0];
              wrColor <= w_src.color;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef BRUSH_PAINTER_DROPCNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign dropCount = r_drop_cnt;
`else
  assign dropCount = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_brush_painter.sv
`default_nettype none
// ============================================================================
// Module  : tb_brush_painter
// Brief   : Directed self-checking bench with a pixel-list reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_brush_painter;

  localparam int SW = 160;
  localparam int SH = 120;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       brushUpdate = 1'b0;
  logic       updateConfig = 1'b0;
  logic       wrReady = 1'b0;
  logic [7:0] x = 8'd0;
  logic [7:0] y = 8'd0;
  logic [2:0] newColorUpdate = 3'd0;
  logic       wrEn;
  logic [7:0] wrX;
  logic [7:0] wrY;
  logic [2:0] wrColor;
  logic       busy;
  logic       overflow;
  logic [7:0] dropCount;

  brush_painter #(.FIFO_DEPTH(4), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .clk            (clk),
    .reset          (reset),
    .brushUpdate    (brushUpdate),
    .x              (x),
    .y              (y),
    .newColorUpdate (newColorUpdate),
    .updateConfig   (updateConfig),
    .wrReady        (wrReady),
    .wrEn           (wrEn),
    .wrX            (wrX),
    .wrY            (wrY),
    .wrColor        (wrColor),
    .busy           (busy),
    .overflow       (overflow),
    .dropCount      (dropCount)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int first_wr = -1;
  int t_pulse = 0;
  int nb_clip = 0;
  int seen_ovf = 0;
  logic [18:0] exp_q[$];
  logic [18:0] got_q[$];
  logic [2:0]  m_color = 3'd0;
  logic [1:0]  m_size = 2'd0;
  logic        prev_stall = 1'b0;
  logic [19:0] prev_vals = '0;
  int          exp_drop;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: every in-bounds pixel of the square, row-major, in plain integers.
  task automatic exp_stroke(input int cx, input int cy, input int c, input int s);
    for (int j = -s; j <= s; j++) begin
      for (int i = -s; i <= s; i++) begin
        int px;
        int py;
        px = cx + i;
        py = cy + j;
        if (px >= 0 && px < SW && py >= 0 && py < SH)
          exp_q.push_back({px[7:0], py[7:0], c[2:0]});
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (overflow) seen_ovf++;
      if (busy && !wrEn) nb_clip++;
      if (wrEn && first_wr < 0) first_wr = cyc;
      if (prev_stall) begin
        n_vec++;
        if ({wrEn, wrX, wrY, wrColor} !== prev_vals) begin
          n_err++;
          $display("FAIL stall_hold: got %h required %h", {wrEn, wrX, wrY, wrColor}, prev_vals);
        end
      end
      if (wrEn) begin
        n_vec++;
        if (exp_q.size() == 0 || !busy) begin
          n_err++;
          $display("FAIL unexpected_wr: got (%0d,%0d,%0d) busy=%0b, required no write", wrX, wrY, wrColor, busy);
        end else if (wrReady) begin
          logic [18:0] e;
          e = exp_q.pop_front();
          if ({wrX, wrY, wrColor} !== e) begin
            n_err++;
            $display("FAIL pixel: got (%0d,%0d,%0d) required (%0d,%0d,%0d)",
                     wrX, wrY, wrColor, e[18:11], e[10:3], e[2:0]);
          end
        end
        if (wrReady) got_q.push_back({wrX, wrY, wrColor});
      end
      prev_stall = wrEn && !wrReady;
      prev_vals  = {wrEn, wrX, wrY, wrColor};
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    n_vec++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", nm, got, req);
    end
  endtask

  task automatic cfg(input logic [2:0] col, input logic [1:0] sz);
    newColorUpdate = col;
    x = {6'd0, sz};
    updateConfig = 1'b1;
    tick;
    updateConfig = 1'b0;
    m_color = col;
    m_size = sz;
  endtask

  task automatic pt(input int px, input int py, input logic acc);
    x = px[7:0];
    y = py[7:0];
    brushUpdate = 1'b1;
    t_pulse = cyc;
    if (acc) exp_stroke(px, py, int'(m_color), int'(m_size));
    tick;
    brushUpdate = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (busy && k < 500) begin
      tick;
      k++;
    end
    chk({nm, "_idle"}, {31'd0, busy}, 32'd0);
    chk({nm, "_left"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic chk_log(input string nm, input int base,
                         input logic [18:0] l0, input logic [18:0] l1,
                         input logic [18:0] l2, input logic [18:0] l3);
    logic [18:0] lit [4];
    lit = '{l0, l1, l2, l3};
    chk({nm, "_count"}, got_q.size() - base, 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < got_q.size()) chk({nm, "_lit"}, {13'd0, got_q[base + i]}, {13'd0, lit[i]});
    end
  endtask

  initial begin
    int base;
    // Reset state
    tick;
    tick;
    chk("rst_wrEn", {31'd0, wrEn}, 0);
    chk("rst_wrXY", {16'd0, wrX, wrY}, 0);
    chk("rst_color", {29'd0, wrColor}, 0);
    chk("rst_busy", {30'd0, busy, overflow}, 0);
    chk("rst_drop", {24'd0, dropCount}, 0);
    reset = 1'b1;
    wrReady = 1'b1;
    tick;

    // Single pixel, latency N+2
    cfg(3'd5, 2'd0);
    first_wr = -1;
    base = got_q.size();
    pt(10, 20, 1'b1);
    wait_idle("single");
    chk("latency", first_wr - t_pulse, 2);
    chk("single_count", got_q.size() - base, 1);
    if (got_q.size() > base) chk("single_lit", {13'd0, got_q[base]}, {13'd0, 8'd10, 8'd20, 3'd5});

    // Top-left corner clipping: 1 pop cycle + 5 clipped cycles with busy and no write
    cfg(3'd4, 2'd1);
    base = got_q.size();
    nb_clip = 0;
    pt(0, 0, 1'b1);
    wait_idle("corner0");
    chk("corner0_clip", nb_clip, 6);
    chk_log("corner0", base, {8'd0, 8'd0, 3'd4}, {8'd1, 8'd0, 3'd4},
            {8'd0, 8'd1, 3'd4}, {8'd1, 8'd1, 3'd4});

    // Bottom-right corner clipping
    cfg(3'd7, 2'd1);
    base = got_q.size();
    pt(159, 119, 1'b1);
    wait_idle("corner1");
    chk_log("corner1", base, {8'd158, 8'd118, 3'd7}, {8'd159, 8'd118, 3'd7},
            {8'd158, 8'd119, 3'd7}, {8'd159, 8'd119, 3'd7});

    // Same-cycle point+config uses old config; later config doesn't touch queued cmd
    cfg(3'd3, 2'd0);
    x = 8'd50;
    y = 8'd60;
    newColorUpdate = 3'd6;
    brushUpdate = 1'b1;
    updateConfig = 1'b1;
    exp_stroke(50, 60, 3, 0);
    tick;
    brushUpdate = 1'b0;
    updateConfig = 1'b0;
    m_color = 3'd6;
    m_size = 2'd2;
    base = got_q.size();
    pt(70, 80, 1'b1);
    wait_idle("samecycle");
    chk("samecycle_count", got_q.size() - base, 26);

    // Backpressure: 10 stalled cycles hold outputs, then full stroke
    wrReady = 1'b0;
    cfg(3'd1, 2'd1);
    base = got_q.size();
    pt(40, 40, 1'b1);
    repeat (10) tick;
    chk("stall_wrEn", {31'd0, wrEn}, 1);
    chk("stall_nowr", got_q.size() - base, 0);
    wrReady = 1'b1;
    wait_idle("stall");
    chk("stall_count", got_q.size() - base, 9);

    // Overflow: stalled stroke in progress, 6 pulses into a 4-deep FIFO
    wrReady = 1'b0;
    cfg(3'd2, 2'd0);
    base = got_q.size();
    seen_ovf = 0;
    pt(30, 30, 1'b1);
    tick;
    tick;
    for (int k = 0; k < 6; k++) begin
      x = 8'(100 + k);
      y = 8'd10;
      brushUpdate = 1'b1;
      if (k < 4) exp_stroke(100 + k, 10, 2, 0);
      tick;
    end
    brushUpdate = 1'b0;
    tick;
    tick;
    chk("ovf_pulses", seen_ovf, 2);
`ifdef BRUSH_PAINTER_DROPCNT_EN
    exp_drop = 2;
`else
    exp_drop = 0;
`endif
    chk("drop_count", {24'd0, dropCount}, exp_drop);
    wrReady = 1'b1;
    wait_idle("ovf");
    chk("ovf_written", got_q.size() - base, 5);

    // Reset mid-stroke with two commands queued
    wrReady = 1'b0;
    cfg(3'd1, 2'd0);
    pt(20, 20, 1'b1);
    tick;
    tick;
    pt(21, 21, 1'b1);
    pt(22, 22, 1'b1);
    chk("pre_rst_busy", {31'd0, busy}, 1);
    base = got_q.size();
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_wrEn", {31'd0, wrEn}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_drop", {24'd0, dropCount}, 0);
    exp_q.delete();
    m_color = 3'd0;
    m_size = 2'd0;
    tick;
    tick;
    reset = 1'b1;
    wrReady = 1'b1;
    repeat (30) tick;
    chk("postrst_busy", {31'd0, busy}, 0);
    chk("postrst_nowr", got_q.size() - base, 0);

    // Config registers came back reset: colour 0, size 0
    pt(5, 5, 1'b1);
    wait_idle("postrst");
    chk("postrst_count", got_q.size() - base, 1);
    if (got_q.size() > base) chk("postrst_lit", {13'd0, got_q[base]}, {13'd0, 8'd5, 8'd5, 3'd0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
